// File: rtl/axi_tb_memory_pkg.sv
// Shared types and helpers for the AXI4 testbench memory.
// Burst/response encodings, FSM state enums, the default AXI channel structs
// and the burst address sequencer.
package axi_tb_memory_pkg;

    localparam int unsigned DefAddrWidth = 48;
    localparam int unsigned DefDataWidth = 64;
    localparam int unsigned DefIdWidth   = 2;
    localparam int unsigned DefUserWidth = 1;

    // Width the address helper works in; wide enough for any AxiAddrWidth used here.
    localparam int unsigned NextAddrWidth = 64;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } w_state_e;

    typedef enum logic {
        RIdle,
        RData
    } r_state_e;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [DefUserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DefDataWidth-1:0]   data;
        logic [DefDataWidth/8-1:0] strb;
        logic                      last;
        logic [DefUserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [DefUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [DefUserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DefIdWidth-1:0]   id;
        logic [DefDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [DefUserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

    // Byte address of the beat following addr. WRAP only wraps for legal
    // lengths (2/4/8/16 beats); anything else, including the reserved burst
    // encoding, steps like INCR.
    function automatic logic [NextAddrWidth-1:0] next_addr(
        input logic [NextAddrWidth-1:0] addr,
        input logic [2:0]               size,
        input logic [7:0]               len,
        input logic [1:0]               burst
    );
        logic [NextAddrWidth-1:0] step;
        logic [NextAddrWidth-1:0] incr;
        logic [NextAddrWidth-1:0] wrap_mask;
        step      = NextAddrWidth'(1) << size;
        incr      = addr + step;
        wrap_mask = (step * (NextAddrWidth'(len) + NextAddrWidth'(1))) - NextAddrWidth'(1);
        case (burst)
            BurstFixed: next_addr = addr;
            BurstWrap: begin
                if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) begin
                    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
                end else begin
                    next_addr = incr;
                end
            end
            default: next_addr = incr;
        endcase
    endfunction

endpackage

// File: rtl/axi_tb_memory_array.sv
// Word-organised storage: byte-enable synchronous write, asynchronous read.
// A same-cycle read of the word being written sees the old contents.
module axi_tb_memory_array #(
    parameter int unsigned MemWords  = 65536,
    parameter int unsigned DataWidth = 64
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [$clog2(MemWords)-1:0]  waddr_i,
    input  logic [DataWidth-1:0]         wdata_i,
    input  logic [DataWidth/8-1:0]       wstrb_i,
    input  logic [$clog2(MemWords)-1:0]  raddr_i,
    output logic [DataWidth-1:0]         rdata_o
);

    logic [DataWidth-1:0] mem_q [MemWords];

    // Strobed byte writes; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DataWidth / 8; i++) begin
            if (we_i && wstrb_i[i]) begin
                mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_tb_memory.sv
// AXI4 slave memory with independent single-burst write and read engines.
// Optional macro AXI_TB_MEMORY_OOR_ERR_EN: word indices >= MemWords return
// SLVERR (writes dropped, reads give 0) instead of wrapping modulo MemWords.
module axi_tb_memory
    import axi_tb_memory_pkg::*;
#(
    parameter int unsigned AxiAddrWidth = 48,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 2,
    parameter int unsigned AxiUserWidth = 1,
    parameter int unsigned MemWords     = 65536,
    parameter type         req_t        = axi_req_t,
    parameter type         rsp_t        = axi_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t req_i,
    output rsp_t rsp_o
);

    localparam int unsigned OffBits = $clog2(AxiDataWidth / 8);
    localparam int unsigned IdxBits = $clog2(MemWords);

    w_state_e                w_state_q, w_state_d;
    logic [AxiAddrWidth-1:0] waddr_q, waddr_d;
    logic [7:0]              wlen_q, wlen_d;
    logic [2:0]              wsize_q, wsize_d;
    logic [1:0]              wburst_q, wburst_d;
    logic [AxiIdWidth-1:0]   wid_q, wid_d;
    logic [7:0]              wbeat_q, wbeat_d;
    logic                    werr_q, werr_d;

    r_state_e                r_state_q, r_state_d;
    logic [AxiAddrWidth-1:0] raddr_q, raddr_d;
    logic [7:0]              rlen_q, rlen_d;
    logic [2:0]              rsize_q, rsize_d;
    logic [1:0]              rburst_q, rburst_d;
    logic [AxiIdWidth-1:0]   rid_q, rid_d;
    logic [7:0]              rbeat_q, rbeat_d;

    logic [NextAddrWidth-1:0] waddr_nxt, raddr_nxt;
    logic [IdxBits-1:0]       widx, ridx;
    logic                     w_oor, r_oor;
    logic                     mem_we;
    logic [AxiDataWidth-1:0]  mem_rdata;
    logic [AxiUserWidth-1:0]  user_zero;
    logic                     aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic                     unused_bits;

    assign widx      = waddr_q[OffBits +: IdxBits];
    assign ridx      = raddr_q[OffBits +: IdxBits];
    assign waddr_nxt = next_addr(NextAddrWidth'(waddr_q), wsize_q, wlen_q, wburst_q);
    assign raddr_nxt = next_addr(NextAddrWidth'(raddr_q), rsize_q, rlen_q, rburst_q);
    assign user_zero = '0;

`ifdef AXI_TB_MEMORY_OOR_ERR_EN
    assign w_oor = |waddr_q[AxiAddrWidth-1:OffBits+IdxBits];
    assign r_oor = |raddr_q[AxiAddrWidth-1:OffBits+IdxBits];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    // Sideband fields (cache, prot, atop, ...) and upper address bits have no effect.
    assign unused_bits = ^{req_i, waddr_q, raddr_q, waddr_nxt, raddr_nxt};

    // Write engine next state: AW latch, strobed beats, single B response.
    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wid_d     = wid_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        mem_we    = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                aw_ready = 1'b1;
                if (req_i.aw_valid) begin
                    waddr_d   = req_i.aw.addr;
                    wlen_d    = req_i.aw.len;
                    wsize_d   = req_i.aw.size;
                    wburst_d  = req_i.aw.burst;
                    wid_d     = req_i.aw.id;
                    wbeat_d   = 8'd0;
                    werr_d    = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                w_ready = 1'b1;
                if (req_i.w_valid) begin
                    mem_we  = !w_oor;
                    werr_d  = werr_q | w_oor;
                    waddr_d = waddr_nxt[AxiAddrWidth-1:0];
                    wbeat_d = wbeat_q + 8'd1;
                    // Whichever of w_last or the beat count comes first ends the burst.
                    if (req_i.w.last || wbeat_q == wlen_q) begin
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                b_valid = 1'b1;
                if (req_i.b_ready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Read engine next state: AR latch, then one R beat per r_ready.
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rid_d     = rid_q;
        rbeat_d   = rbeat_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                ar_ready = 1'b1;
                if (req_i.ar_valid) begin
                    raddr_d   = req_i.ar.addr;
                    rlen_d    = req_i.ar.len;
                    rsize_d   = req_i.ar.size;
                    rburst_d  = req_i.ar.burst;
                    rid_d     = req_i.ar.id;
                    rbeat_d   = 8'd0;
                    r_state_d = RData;
                end
            end
            RData: begin
                r_valid = 1'b1;
                if (req_i.r_ready) begin
                    raddr_d = raddr_nxt[AxiAddrWidth-1:0];
                    rbeat_d = rbeat_q + 8'd1;
                    if (rbeat_q == rlen_q) begin
                        r_state_d = RIdle;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Engine state registers; reset aborts any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= WIdle;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wid_q     <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            r_state_q <= RIdle;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rid_q     <= '0;
            rbeat_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wid_q     <= wid_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rid_q     <= rid_d;
            rbeat_q   <= rbeat_d;
        end
    end

    // Response bundle; handshake signals are forced low while in reset.
    always_comb begin
        rsp_o          = '0;
        rsp_o.aw_ready = aw_ready & rst_ni;
        rsp_o.w_ready  = w_ready & rst_ni;
        rsp_o.b_valid  = b_valid & rst_ni;
        rsp_o.ar_ready = ar_ready & rst_ni;
        rsp_o.r_valid  = r_valid & rst_ni;
        rsp_o.b.id     = wid_q;
        rsp_o.b.resp   = werr_q ? RespSlverr : RespOkay;
        rsp_o.b.user   = user_zero;
        rsp_o.r.id     = rid_q;
        rsp_o.r.data   = r_oor ? '0 : mem_rdata;
        rsp_o.r.resp   = r_oor ? RespSlverr : RespOkay;
        rsp_o.r.last   = (rbeat_q == rlen_q);
        rsp_o.r.user   = user_zero;
    end

    axi_tb_memory_array #(
        .MemWords  (MemWords),
        .DataWidth (AxiDataWidth)
    ) i_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (widx),
        .wdata_i (req_i.w.data),
        .wstrb_i (req_i.w.strb),
        .raddr_i (ridx),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi_tb_memory.sv
// Directed bench for axi_tb_memory: reset, single/strobed/burst accesses,
// wrap sequencing, backpressure, out-of-range handling and reset abort.
module tb_axi_tb_memory;
    import axi_tb_memory_pkg::*;

`ifdef AXI_TB_MEMORY_OOR_ERR_EN
    localparam bit OorEn = 1'b1;
`else
    localparam bit OorEn = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rst_n;
    axi_req_t req;
    axi_rsp_t rsp;
    int       n_tests = 0;
    int       n_fail  = 0;
    logic [5:0] atop_val = '0;

    always #5 clk = ~clk;

    axi_tb_memory #(
        .AxiAddrWidth (48),
        .AxiDataWidth (64),
        .AxiIdWidth   (2),
        .AxiUserWidth (1),
        .MemWords     (65536),
        .req_t        (axi_req_t),
        .rsp_t        (axi_rsp_t)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .rsp_o  (rsp)
    );

    // Channel drivers: entered and left at posedge+1.
    task automatic aw_send(input logic [47:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] id);
        bit hs = 0;
        int cnt = 0;
        req.aw       = '0;
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = 3'd3;
        req.aw.burst = burst;
        req.aw.atop  = atop_val;
        req.aw_valid = 1'b1;
        while (!hs && cnt < 100) begin
            @(negedge clk); hs = rsp.aw_ready;
            @(posedge clk); #1; cnt++;
        end
        req.aw_valid = 1'b0;
        if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL aw_handshake: aw_ready=0 for %0d cycles, required 1", cnt);
        end
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        bit hs = 0;
        int cnt = 0;
        req.w       = '0;
        req.w.data  = data;
        req.w.strb  = strb;
        req.w.last  = last;
        req.w_valid = 1'b1;
        while (!hs && cnt < 100) begin
            @(negedge clk); hs = rsp.w_ready;
            @(posedge clk); #1; cnt++;
        end
        req.w_valid = 1'b0;
        if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL w_handshake: w_ready=0 for %0d cycles, required 1", cnt);
        end
    endtask

    task automatic b_recv(output logic [1:0] resp, output logic [1:0] id);
        bit hs = 0;
        int cnt = 0;
        resp = 2'bxx;
        id   = 2'bxx;
        req.b_ready = 1'b1;
        while (!hs && cnt < 100) begin
            @(negedge clk); hs = rsp.b_valid; resp = rsp.b.resp; id = rsp.b.id;
            @(posedge clk); #1; cnt++;
        end
        req.b_ready = 1'b0;
        if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL b_handshake: b_valid=0 for %0d cycles, required 1", cnt);
        end
    endtask

    task automatic ar_send(input logic [47:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] id);
        bit hs = 0;
        int cnt = 0;
        req.ar       = '0;
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = 3'd3;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
        while (!hs && cnt < 100) begin
            @(negedge clk); hs = rsp.ar_ready;
            @(posedge clk); #1; cnt++;
        end
        req.ar_valid = 1'b0;
        if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL ar_handshake: ar_ready=0 for %0d cycles, required 1", cnt);
        end
    endtask

    task automatic r_recv(output logic [63:0] data, output logic [1:0] resp,
                          output logic last, output logic [1:0] id);
        bit hs = 0;
        int cnt = 0;
        data = 'x; resp = 'x; last = 1'bx; id = 'x;
        req.r_ready = 1'b1;
        while (!hs && cnt < 100) begin
            @(negedge clk);
            hs = rsp.r_valid; data = rsp.r.data; resp = rsp.r.resp;
            last = rsp.r.last; id = rsp.r.id;
            @(posedge clk); #1; cnt++;
        end
        req.r_ready = 1'b0;
        if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL r_handshake: r_valid=0 for %0d cycles, required 1", cnt);
        end
    endtask

    task automatic test_reset();
        req   = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 00000",
                     {rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid} !== 5'b10100) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b, expected 10100",
                     {rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [1:0]  resp, id;
        logic [63:0] d;
        logic        last;
        logic [1:0]  exp_resp = OorEn ? RespSlverr : RespOkay;
        logic [63:0] exp_data = OorEn ? 64'h0 : 64'hDEAD_BEEF_0123_4567;
        aw_send(48'h8000_0100, 8'd0, BurstIncr, 2'b10);
        w_send(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
        b_recv(resp, id);
        n_tests++;
        if (resp !== exp_resp || id !== 2'b10) begin
            n_fail++;
            $display("FAIL single_b: got resp=%h id=%h, expected resp=%h id=2", resp, id, exp_resp);
        end
        ar_send(48'h8000_0100, 8'd0, BurstIncr, 2'b01);
        @(negedge clk);
        n_tests++;
        if (rsp.r_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL r_latency: got r_valid=%b one cycle after AR, expected 1", rsp.r_valid);
        end
        @(posedge clk); #1;
        r_recv(d, resp, last, id);
        n_tests++;
        if (d !== exp_data || last !== 1'b1 || id !== 2'b01 || resp !== exp_resp) begin
            n_fail++;
            $display("FAIL single_r: got data=%h last=%b id=%h resp=%h, expected %h 1 1 %h",
                     d, last, id, resp, exp_data, exp_resp);
        end
    endtask

    task automatic test_byte_strobe();
        logic [1:0]  resp, id;
        logic [63:0] d;
        logic        last;
        aw_send(48'h200, 8'd0, BurstIncr, 2'b00);
        w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        b_recv(resp, id);
        aw_send(48'h200, 8'd0, BurstIncr, 2'b00);
        w_send(64'h0000_0000_0000_0011, 8'h01, 1'b1);
        b_recv(resp, id);
        n_tests++;
        if (resp !== RespOkay) begin
            n_fail++;
            $display("FAIL strobe_b: got resp=%h, expected 0", resp);
        end
        ar_send(48'h200, 8'd0, BurstIncr, 2'b00);
        r_recv(d, resp, last, id);
        n_tests++;
        if (d !== 64'hFFFF_FFFF_FFFF_FF11) begin
            n_fail++;
            $display("FAIL strobe_r: got %h, expected ffffffffffffff11", d);
        end
    endtask

    task automatic test_incr_burst();
        logic [1:0]  resp, id;
        logic [63:0] d;
        logic        last;
        aw_send(48'h1000, 8'd3, BurstIncr, 2'b11);
        for (int i = 0; i < 4; i++) w_send(64'(i + 1), 8'hFF, i == 3);
        b_recv(resp, id);
        n_tests++;
        if (resp !== RespOkay || id !== 2'b11) begin
            n_fail++;
            $display("FAIL incr_b: got resp=%h id=%h, expected 0 3", resp, id);
        end
        ar_send(48'h1000, 8'd3, BurstIncr, 2'b01);
        for (int i = 0; i < 4; i++) begin
            r_recv(d, resp, last, id);
            n_tests++;
            if (d !== 64'(i + 1) || last !== (i == 3)) begin
                n_fail++;
                $display("FAIL incr_r%0d: got data=%h last=%b, expected %h %b",
                         i, d, last, 64'(i + 1), i == 3);
            end
        end
    endtask

    task automatic test_wrap_burst();
        logic [1:0]  resp, id;
        logic [63:0] d;
        logic        last;
        logic [47:0] addrs [4] = '{48'h1010, 48'h1018, 48'h1000, 48'h1008};
        aw_send(48'h1010, 8'd3, BurstWrap, 2'b00);
        for (int i = 0; i < 4; i++) w_send(64'hA0 + 64'(i), 8'hFF, i == 3);
        b_recv(resp, id);
        for (int i = 0; i < 4; i++) begin
            ar_send(addrs[i], 8'd0, BurstIncr, 2'b00);
            r_recv(d, resp, last, id);
            n_tests++;
            if (d !== 64'hA0 + 64'(i)) begin
                n_fail++;
                $display("FAIL wrap_loc%0d: got %h at %h, expected %h",
                         i, d, addrs[i], 64'hA0 + 64'(i));
            end
        end
        ar_send(48'h1010, 8'd3, BurstWrap, 2'b00);
        for (int i = 0; i < 4; i++) begin
            r_recv(d, resp, last, id);
            n_tests++;
            if (d !== 64'hA0 + 64'(i) || last !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_r%0d: got data=%h last=%b, expected %h %b",
                         i, d, last, 64'hA0 + 64'(i), i == 3);
            end
        end
    endtask

    // Relies on the wrap test layout: 0x1000=A2, 0x1008=A3, 0x1010=A0, 0x1018=A1.
    task automatic test_backpressure();
        logic [1:0]  resp, id;
        logic [63:0] d;
        logic        last;
        logic [63:0] exp_tail [3] = '{64'hA3, 64'hA0, 64'hA1};
        ar_send(48'h1000, 8'd3, BurstIncr, 2'b10);
        r_recv(d, resp, last, id);
        n_tests++;
        if (d !== 64'hA2) begin
            n_fail++;
            $display("FAIL bp_r0: got %h, expected a2", d);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp.r_valid !== 1'b1 || rsp.r.data !== 64'hA3 || rsp.r.last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b, expected 1 a3 0",
                         i, rsp.r_valid, rsp.r.data, rsp.r.last);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            r_recv(d, resp, last, id);
            n_tests++;
            if (d !== exp_tail[i] || last !== (i == 2) || id !== 2'b10) begin
                n_fail++;
                $display("FAIL bp_r%0d: got data=%h last=%b id=%h, expected %h %b 2",
                         i + 1, d, last, id, exp_tail[i], i == 2);
            end
        end
        aw_send(48'h300, 8'd0, BurstIncr, 2'b01);
        w_send(64'h33, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (rsp.b_valid !== 1'b1 || rsp.aw_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b_hold%0d: got b_valid=%b aw_ready=%b, expected 1 0",
                         i, rsp.b_valid, rsp.aw_ready);
            end
            @(posedge clk); #1;
        end
        b_recv(resp, id);
        @(negedge clk);
        n_tests++;
        if (rsp.aw_ready !== 1'b1 || id !== 2'b01) begin
            n_fail++;
            $display("FAIL b_release: got aw_ready=%b id=%h, expected 1 1", rsp.aw_ready, id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp, id;
        logic [63:0] d;
        logic        last;
        logic [1:0]  exp_resp = OorEn ? RespSlverr : RespOkay;
        logic [63:0] exp_word0 = OorEn ? 64'h5555 : 64'h7777;
        aw_send(48'h0, 8'd0, BurstIncr, 2'b00);
        w_send(64'h5555, 8'hFF, 1'b1);
        b_recv(resp, id);
        // Word index 65536 = MemWords.
        aw_send(48'h8_0000, 8'd0, BurstIncr, 2'b00);
        w_send(64'h7777, 8'hFF, 1'b1);
        b_recv(resp, id);
        n_tests++;
        if (resp !== exp_resp) begin
            n_fail++;
            $display("FAIL oor_b: got resp=%h, expected %h", resp, exp_resp);
        end
        ar_send(48'h0, 8'd0, BurstIncr, 2'b00);
        r_recv(d, resp, last, id);
        n_tests++;
        if (d !== exp_word0) begin
            n_fail++;
            $display("FAIL oor_word0: got %h, expected %h", d, exp_word0);
        end
    endtask

    task automatic test_fixed_atop();
        logic [1:0]  resp, id;
        logic [63:0] d;
        logic        last;
        atop_val = 6'h20;
        aw_send(48'h400, 8'd1, BurstFixed, 2'b00);
        atop_val = 6'h00;
        w_send(64'hAAAA, 8'hFF, 1'b0);
        w_send(64'hBBBB, 8'hFF, 1'b1);
        b_recv(resp, id);
        @(negedge clk);
        n_tests++;
        if (resp !== RespOkay || rsp.r_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL atop_b: got resp=%h r_valid=%b, expected 0 0", resp, rsp.r_valid);
        end
        @(posedge clk); #1;
        ar_send(48'h400, 8'd0, BurstIncr, 2'b00);
        r_recv(d, resp, last, id);
        n_tests++;
        if (d !== 64'hBBBB) begin
            n_fail++;
            $display("FAIL fixed_r: got %h, expected bbbb", d);
        end
    endtask

    task automatic test_reset_abort();
        aw_send(48'h500, 8'd3, BurstIncr, 2'b00);
        w_send(64'h1234, 8'hFF, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rsp.aw_ready, rsp.w_ready, rsp.b_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_in_reset: got %b, expected 000",
                     {rsp.aw_ready, rsp.w_ready, rsp.b_valid});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rsp.aw_ready, rsp.w_ready, rsp.b_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_idle: got %b, expected 100",
                     {rsp.aw_ready, rsp.w_ready, rsp.b_valid});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_byte_strobe();
        test_incr_burst();
        test_wrap_burst();
        test_backpressure();
        test_out_of_range();
        test_fixed_atop();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_tb_memory.md
Name: axi_tb_memory

Overview:
- AXI4 slave backed by a word-organised memory array; used as the narrow (64-bit) and wide (512-bit) backing store behind the cluster's outbound ports in the cluster testharness.
- Write and read channels are independent engines, each serving one burst at a time.
- Responses are always in order.

Parameters:
- AxiAddrWidth, 48: AXI address width.
- AxiDataWidth, 64: data width in bits (power of two, 32..1024).
- AxiIdWidth, 2: ID width; IDs are echoed unchanged on B/R.
- AxiUserWidth, 1: user width; B/R user driven to 0.
- MemWords, 65536: depth in AxiDataWidth-bit words (power of two).
- req_t, logic: AXI request struct type (aw/w/ar channels plus b_ready, r_ready).
- rsp_t, logic: AXI response struct type (aw_ready, w_ready, ar_ready, b, r).

Ports:
- clk_i  input  1  clock; rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_i  input  req_t  AXI request bundle from master.
- rsp_o  output  rsp_t  AXI response bundle to master.

Behaviour:
Reset:
- All rsp_o valid/ready fields are 0 while rst_ni=0. Both FSMs return to IDLE.
- Memory contents are not reset.

Addressing:
- Word index = (addr >> log2(AxiDataWidth/8)) modulo MemWords; upper bits are ignored.

Write FSM (states W_IDLE, W_DATA, W_RESP):
- W_IDLE: aw_ready=1. On aw_valid&aw_ready, latch id, addr, len, size, burst, and set beat count to 0; next state W_DATA.
- W_DATA: w_ready=1. Each w handshake writes the bytes whose w_strb bit is 1 into the current word, then advances the address.
- W_DATA exits to W_RESP on the beat with w_last=1, or when the beat count reaches len. w_last and the count disagreeing is still exited on whichever occurs first.
- W_RESP: b_valid=1, b.id=latched id, b.resp=OKAY. Hold until b_ready, then go to W_IDLE. The next AW is accepted the cycle after the B handshake.
- Write data is visible to reads the cycle after the W handshake.

Read FSM (states R_IDLE, R_DATA):
- R_IDLE: ar_ready=1. On handshake, latch fields; next state R_DATA.
- R_DATA: r_valid=1, r.data=full word at the current address (combinational from the array), r.id=latched id, r.resp=OKAY, r.last=(beat==len).
- On r_ready, advance the address and the beat count. After the last beat, go to R_IDLE.
- First R beat is valid one cycle after the AR handshake.
- r.data, r.id and r.last are held stable while r_valid & !r_ready.

Burst address rules:
- FIXED: address constant.
- INCR: addr += 2^size, computed on the byte address.
- WRAP: increment within a 2^size*(len+1)-aligned window, wrapping to the window base. len+1 must be 2, 4, 8 or 16; other lengths are treated as INCR.
- Reserved burst type (2'b11) is treated as INCR.
- Narrow transfers (size < bus width): writes rely on the master's strobes; reads return the full bus word.

Simultaneous events:
- Read and write to the same word in the same cycle: the read returns the old data.
- Atomic operations (aw.atop != 0) are executed as plain writes, with a B response only; no R beat.
- Reset asserted mid-burst aborts the burst immediately; no B or R is issued for it.

Optional Feature:
- Macro AXI_TB_MEMORY_OOR_ERR_EN.
- Defined: beats whose word index is >= MemWords (before modulo) are out of range. Such writes are dropped and B.resp=SLVERR if any beat of the burst was out of range. Such reads return data 0 with resp=SLVERR for that beat.
- Undefined: addresses wrap modulo MemWords and all responses are OKAY.

Decomposition:
- Package axi_tb_memory_pkg holds:
  - write-state enum and read-state enum;
  - burst/resp localparams (reuse axi_pkg types);
  - a function next_addr(addr, size, len, burst) implementing FIXED/INCR/WRAP.
- One sub-module, axi_tb_memory_array: byte-enable write port plus asynchronous read port, MemWords x AxiDataWidth.

Test Plan:
- Single write then read: AW addr 0x8000_0100, len 0, full strobe, data 0xDEAD_BEEF_0123_4567. B OKAY with the same id. AR to the same address returns that data, last=1.
- Byte strobe: preload 0xFFFF_FFFF_FFFF_FFFF, write 0x11 with strb 0x01 → read returns 0xFFFF_FFFF_FFFF_FF11.
- INCR burst len 3 at 0x1000, data 1, 2, 3, 4 → read burst returns 1, 2, 3, 4, with last only on beat 4.
- WRAP burst len 3 starting at 0x1010 (8-byte beats) touches 0x1010, 0x1018, 0x1000, 0x1008; read back in the same order.
- Backpressure: hold r_ready=0 for 5 cycles mid-burst → r_valid stays 1 and data stays stable. Hold b_ready=0 for 3 cycles → b_valid held, and aw_ready stays 0 until the B handshake.
- With AXI_TB_MEMORY_OOR_ERR_EN: write to word index MemWords → B SLVERR and memory unchanged. Without the macro the same write lands at word 0.
